// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Initiator side of the ALU interface in the multi-cycle datapath. Accepts one
//   decoded-instruction request at a time over valid/ready and encodes the ALU
//   operation. It drives the operands to the ALU, waits for the result, then
//   returns the captured result, ZERO, branch-taken and illegal flags over
//   valid/ready.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   req_valid / req_ready         request handshake (ready only in IDLE)
//   req_aluop, req_funct3,
//   req_funct7b5                  decoded instruction fields
//   req_rs1, req_rs2              operands (rs2 may carry an immediate)
//   ALU_Operation, Data1, Data2   registered drive to the ALU
//   ALU_result, ZERO              ALU outputs
//   rsp_valid / rsp_ready         response handshake
//   rsp_result, rsp_zero,
//   rsp_branch_taken, rsp_illegal captured response fields
module alu_issue_ctrl #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned ALU_WAIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_aluop,
    input  logic [2:0]       req_funct3,
    input  logic             req_funct7b5,
    input  logic [WIDTH-1:0] req_rs1,
    input  logic [WIDTH-1:0] req_rs2,
    output logic [3:0]       ALU_Operation,
    output logic [WIDTH-1:0] Data1,
    output logic [WIDTH-1:0] Data2,
    input  logic [WIDTH-1:0] ALU_result,
    input  logic             ZERO,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_branch_taken,
    output logic             rsp_illegal
);

    localparam int unsigned CW = $clog2(ALU_WAIT + 1);

    localparam logic [3:0] OpAnd = 4'b0000;
    localparam logic [3:0] OpOr  = 4'b0001;
    localparam logic [3:0] OpAdd = 4'b0010;
    localparam logic [3:0] OpSub = 4'b0110;

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic          is_branch;
    logic          is_bne;
    logic [3:0]    dec_op;
    logic          dec_illegal;

    // Operation decode from the live request fields.
    always_comb begin
        dec_op      = OpAdd;
        dec_illegal = 1'b0;
        unique case (req_aluop)
            2'b00: dec_op = OpAdd;
            2'b01: begin
                dec_op      = OpSub;
                dec_illegal = (req_funct3 != 3'b000) && (req_funct3 != 3'b001);
            end
            2'b10: begin
                case (req_funct3)
                    3'b000:  dec_op = req_funct7b5 ? OpSub : OpAdd;
                    3'b110:  dec_op = OpOr;
                    3'b111:  dec_op = OpAnd;
                    default: dec_illegal = 1'b1;
                endcase
            end
            2'b11: begin
                case (req_funct3)
                    3'b000:  dec_op = OpAdd;
                    3'b110:  dec_op = OpOr;
                    3'b111:  dec_op = OpAnd;
                    default: dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= StIdle;
            wait_cnt         <= '0;
            req_ready        <= 1'b0;
            ALU_Operation    <= 4'b0000;
            Data1            <= '0;
            Data2            <= '0;
            is_branch        <= 1'b0;
            is_bne           <= 1'b0;
            rsp_valid        <= 1'b0;
            rsp_result       <= '0;
            rsp_zero         <= 1'b0;
            rsp_branch_taken <= 1'b0;
            rsp_illegal      <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    // req_ready is registered, so it first rises one cycle after reset.
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        if (dec_illegal) begin
                            // ALU drive is left untouched; respond immediately.
                            rsp_valid        <= 1'b1;
                            rsp_illegal      <= 1'b1;
                            rsp_result       <= '0;
                            rsp_zero         <= 1'b0;
                            rsp_branch_taken <= 1'b0;
                            state            <= StResp;
                        end else begin
                            ALU_Operation <= dec_op;
                            Data1         <= req_rs1;
                            Data2         <= req_rs2;
                            is_branch     <= (req_aluop == 2'b01);
                            is_bne        <= req_funct3[0];
                            // One issue cycle plus ALU_WAIT settle cycles before capture.
                            wait_cnt      <= CW'(ALU_WAIT);
                            state         <= StExec;
                        end
                    end
                end
                StExec: begin
                    if (wait_cnt == '0) begin
                        rsp_valid        <= 1'b1;
                        rsp_illegal      <= 1'b0;
                        rsp_result       <= ALU_result;
                        rsp_zero         <= ZERO;
                        rsp_branch_taken <= is_branch & (is_bne ? ~ZERO : ZERO);
                        state            <= StResp;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
